// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: memory access sizes and MEM-stage FSM states.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/data_ram.sv
// Local data RAM: word-organised, four byte lanes, synchronous write, asynchronous read.
module data_ram #(
  parameter int unsigned B      = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [B-1:0]      wdata,
  output logic [B-1:0]      rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [B-1:0] mem [Depth];

  // Byte-lane write; contents are never cleared, reset leaves them intact.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: local data RAM access with configurable latency, stall generation,
// load alignment/extension and write-back gating toward the MEM/WB latch.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned B      = 32,
  parameter int unsigned W      = 5,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LAT    = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [B-1:0] alu_result_in,
  input  logic [B-1:0] write_data_in,
  input  logic [W-1:0] mux_RegDst_in,
  input  logic         m_MemRead,
  input  logic         m_MemWrite,
  input  logic [1:0]   m_size,
  input  logic         m_unsigned,
  input  logic         wb_RegWrite_in,
  input  logic         wb_MemtoReg_in,
  output logic [B-1:0] read_data_out,
  output logic [B-1:0] alu_result_out,
  output logic [W-1:0] mux_RegDst_out,
  output logic         wb_RegWrite_out,
  output logic         wb_MemtoReg_out,
  output logic         stall,
  output logic         misalign
);

  // Counter preload on entering WAIT; unused when LAT is zero.
  localparam logic [2:0] LatInit = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  mem_state_t  state;
  logic [2:0]  cnt;

  logic        access;
  logic        misal_raw;
  logic        aligned_access;
  logic        stall_raw;
  logic        commit;
  logic [1:0]  lane;
  logic [3:0]  byte_en;
  logic [B-1:0] store_data;
  logic [B-1:0] ram_rdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [B-1:0] load_data;
  logic        ram_we;

  assign access         = m_MemRead | m_MemWrite;
  assign lane           = alu_result_in[1:0];
  assign aligned_access = access & ~misal_raw;

  // Upper address bits beyond the RAM are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^alu_result_in[B-1:ADDR_W+2];

  // Alignment rule: halves need addr[0]=0, words (and reserved size) need addr[1:0]=0.
  always_comb begin
    misal_raw = 1'b0;
    case (m_size)
      SZ_BYTE: misal_raw = 1'b0;
      SZ_HALF: misal_raw = lane[0];
      default: misal_raw = (lane != 2'b00);
    endcase
  end

  // Stall until the last cycle of the access; that last cycle is the commit cycle.
  always_comb begin
    stall_raw = 1'b0;
    if (aligned_access && (LAT != 0)) begin
      if (state == S_IDLE) begin
        stall_raw = 1'b1;
      end else begin
        stall_raw = (cnt != 3'd0);
      end
    end
  end

  assign commit = aligned_access & ~stall_raw;

  // Latency FSM: IDLE -> WAIT(cnt=LAT-1) -> count down -> IDLE on the commit edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (aligned_access && (LAT != 0)) begin
            state <= S_WAIT;
            cnt   <= LatInit;
          end
        end
        S_WAIT: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    byte_en    = 4'b1111;
    store_data = write_data_in;
    case (m_size)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << lane;
        store_data = {4{write_data_in[7:0]}};
      end
      SZ_HALF: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{write_data_in[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        store_data = write_data_in;
      end
    endcase
  end

  // Reset blocks a store that has not yet reached its commit edge.
  assign ram_we = commit & m_MemWrite & ~reset;

  data_ram #(
    .B      (B),
    .ADDR_W (ADDR_W)
  ) u_data_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (byte_en),
    .addr  (alu_result_in[ADDR_W+1:2]),
    .wdata (store_data),
    .rdata (ram_rdata)
  );

  assign byte_sel = ram_rdata[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? ram_rdata[16 +: 16] : ram_rdata[0 +: 16];

  // Load lane select and sign/zero extension; word loads ignore m_unsigned.
  always_comb begin
    load_data = ram_rdata;
    case (m_size)
      SZ_BYTE: load_data = {{(B-8){~m_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{(B-16){~m_unsigned & half_sel[15]}}, half_sel};
      default: load_data = ram_rdata;
    endcase
  end

  assign read_data_out   = (~reset & m_MemRead & ~misal_raw) ? load_data : '0;
  assign misalign        = ~reset & access & misal_raw;
  assign stall           = ~reset & stall_raw;
  assign wb_RegWrite_out = ~reset & wb_RegWrite_in & ~stall_raw & ~(access & misal_raw);

  assign alu_result_out  = alu_result_in;
  assign mux_RegDst_out  = mux_RegDst_in;
  assign wb_MemtoReg_out = wb_MemtoReg_in;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances at LAT 0, 2 and 3 driven from one sequencer,
// expected results queued at drive time and popped on each commit cycle.
module tb_mem_stage;
  import mips_pkg::*;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [31:0] alu_in  [NI];
  logic [31:0] wd_in   [NI];
  logic [4:0]  rd_in   [NI];
  logic        mr      [NI];
  logic        mw      [NI];
  logic [1:0]  sz      [NI];
  logic        uns     [NI];
  logic        rwi     [NI];
  logic        m2ri    [NI];
  logic [31:0] rdo     [NI];
  logic [31:0] alu_out [NI];
  logic [4:0]  rd_out  [NI];
  logic        rwo     [NI];
  logic        m2ro    [NI];
  logic        stl     [NI];
  logic        mis     [NI];

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        chk_data;
    logic        rw;
    logic        mis;
    int          stalls;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        m2r;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.LAT(0)) u_lat0 (
    .clk(clk), .reset(reset), .alu_result_in(alu_in[0]), .write_data_in(wd_in[0]),
    .mux_RegDst_in(rd_in[0]), .m_MemRead(mr[0]), .m_MemWrite(mw[0]), .m_size(sz[0]),
    .m_unsigned(uns[0]), .wb_RegWrite_in(rwi[0]), .wb_MemtoReg_in(m2ri[0]),
    .read_data_out(rdo[0]), .alu_result_out(alu_out[0]), .mux_RegDst_out(rd_out[0]),
    .wb_RegWrite_out(rwo[0]), .wb_MemtoReg_out(m2ro[0]), .stall(stl[0]), .misalign(mis[0])
  );

  mem_stage #(.LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .alu_result_in(alu_in[1]), .write_data_in(wd_in[1]),
    .mux_RegDst_in(rd_in[1]), .m_MemRead(mr[1]), .m_MemWrite(mw[1]), .m_size(sz[1]),
    .m_unsigned(uns[1]), .wb_RegWrite_in(rwi[1]), .wb_MemtoReg_in(m2ri[1]),
    .read_data_out(rdo[1]), .alu_result_out(alu_out[1]), .mux_RegDst_out(rd_out[1]),
    .wb_RegWrite_out(rwo[1]), .wb_MemtoReg_out(m2ro[1]), .stall(stl[1]), .misalign(mis[1])
  );

  mem_stage #(.LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .alu_result_in(alu_in[2]), .write_data_in(wd_in[2]),
    .mux_RegDst_in(rd_in[2]), .m_MemRead(mr[2]), .m_MemWrite(mw[2]), .m_size(sz[2]),
    .m_unsigned(uns[2]), .wb_RegWrite_in(rwi[2]), .wb_MemtoReg_in(m2ri[2]),
    .read_data_out(rdo[2]), .alu_result_out(alu_out[2]), .mux_RegDst_out(rd_out[2]),
    .wb_RegWrite_out(rwo[2]), .wb_MemtoReg_out(m2ro[2]), .stall(stl[2]), .misalign(mis[2])
  );

  function automatic int lat_of(input int i);
    case (i)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input logic r, input logic w, input logic [1:0] s,
                       input logic u, input logic [31:0] a, input logic [31:0] d,
                       input logic rw);
    mr[i]     = r;
    mw[i]     = w;
    sz[i]     = s;
    uns[i]    = u;
    alu_in[i] = a;
    wd_in[i]  = d;
    rwi[i]    = rw;
    m2ri[i]   = r;
    rd_in[i]  = 5'(a[4:0] + 5'd3);
  endtask

  task automatic idle(input int i);
    drive(i, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Present one instruction, queue its expectation, hold it until commit and compare.
  task automatic run_op(input string name, input int i, input logic r, input logic w,
                        input logic [1:0] s, input logic u, input logic [31:0] a,
                        input logic [31:0] d, input logic rw, input logic [31:0] ed,
                        input logic em);
    exp_t e;
    exp_t got_e;
    int   nst;
    bit   done;
    @(posedge clk);
    #1;
    drive(i, r, w, s, u, a, d, rw);
    e.idx      = i;
    e.data     = em ? 32'h0 : ed;
    e.chk_data = r | em;
    e.rw       = rw & ~em;
    e.mis      = em;
    e.stalls   = ((r | w) && !em) ? lat_of(i) : 0;
    e.alu      = a;
    e.rd       = 5'(a[4:0] + 5'd3);
    e.m2r      = r;
    exp_q.push_back(e);
    nst  = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (stl[i]) begin
        nst++;
        check({name, "_bubble_rw"}, 32'(rwo[i]), 32'h0);
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      check({name, "_timeout"}, 32'(stl[i]), 32'h0);
      void'(exp_q.pop_front());
    end else begin
      got_e = exp_q.pop_front();
      if (got_e.chk_data) check({name, "_data"}, rdo[i], got_e.data);
      check({name, "_rw"}, 32'(rwo[i]), 32'(got_e.rw));
      check({name, "_mis"}, 32'(mis[i]), 32'(got_e.mis));
      check({name, "_stalls"}, 32'(nst), 32'(got_e.stalls));
      check({name, "_alu"}, alu_out[i], got_e.alu);
      check({name, "_rd"}, 32'(rd_out[i]), 32'(got_e.rd));
      check({name, "_m2r"}, 32'(m2ro[i]), 32'(got_e.m2r));
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) idle(i);
    // Outputs must be forced quiet while reset is high, even with live requests.
    drive(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1);
    drive(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall0", 32'(stl[0]), 32'h0);
    check("rst_stall2", 32'(stl[1]), 32'h0);
    check("rst_rw", 32'(rwo[0]), 32'h0);
    check("rst_rdata", rdo[0], 32'h0);
    check("rst_mis", 32'(mis[1]), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(0);
    idle(1);

    // LAT=0 word store/load and sub-word loads.
    run_op("l0_sw",   0, 0, 1, SZ_WORD, 0, 32'h10, 32'h11223344, 0, 32'h0, 0);
    run_op("l0_lw",   0, 1, 0, SZ_WORD, 0, 32'h10, 32'h0, 1, 32'h11223344, 0);
    run_op("l0_sw20", 0, 0, 1, SZ_WORD, 0, 32'h20, 32'h80FF7F01, 0, 32'h0, 0);
    run_op("l0_lb",   0, 1, 0, SZ_BYTE, 0, 32'h23, 32'h0, 1, 32'hFFFFFF80, 0);
    run_op("l0_lbu",  0, 1, 0, SZ_BYTE, 1, 32'h23, 32'h0, 1, 32'h00000080, 0);
    run_op("l0_lh",   0, 1, 0, SZ_HALF, 0, 32'h22, 32'h0, 1, 32'hFFFF80FF, 0);
    run_op("l0_lhu",  0, 1, 0, SZ_HALF, 1, 32'h20, 32'h0, 1, 32'h00007F01, 0);
    // Sub-word stores only touch their own lanes.
    run_op("l0_clr",  0, 0, 1, SZ_WORD, 0, 32'h20, 32'h0, 0, 32'h0, 0);
    run_op("l0_sb",   0, 0, 1, SZ_BYTE, 0, 32'h21, 32'h123456AB, 0, 32'h0, 0);
    run_op("l0_lw_sb", 0, 1, 0, SZ_WORD, 0, 32'h20, 32'h0, 1, 32'h0000AB00, 0);
    run_op("l0_sh",   0, 0, 1, SZ_HALF, 0, 32'h22, 32'h9999CDEF, 0, 32'h0, 0);
    run_op("l0_lw_sh", 0, 1, 0, SZ_WORD, 0, 32'h20, 32'h0, 1, 32'hCDEFAB00, 0);
    // Misaligned accesses: flagged, no write-back, no RAM write.
    run_op("l0_lw_mis", 0, 1, 0, SZ_WORD, 0, 32'h12, 32'h0, 1, 32'h0, 1);
    run_op("l0_sw_mis", 0, 0, 1, SZ_WORD, 0, 32'h11, 32'hDEADBEEF, 0, 32'h0, 1);
    run_op("l0_sh_mis", 0, 0, 1, SZ_HALF, 0, 32'h13, 32'hDEADBEEF, 0, 32'h0, 1);
    run_op("l0_lw_keep", 0, 1, 0, SZ_WORD, 0, 32'h10, 32'h0, 1, 32'h11223344, 0);
    @(posedge clk);
    #1;
    idle(0);

    // LAT=2: two stall cycles, then commit; a following ALU op passes straight through.
    run_op("l2_sw",   1, 0, 1, SZ_WORD, 0, 32'h10, 32'h11223344, 0, 32'h0, 0);
    run_op("l2_lw",   1, 1, 0, SZ_WORD, 0, 32'h10, 32'h0, 1, 32'h11223344, 0);
    run_op("l2_add",  1, 0, 0, SZ_WORD, 0, 32'h0000ABCD, 32'h0, 1, 32'h0, 0);
    run_op("l2_lw_mis", 1, 1, 0, SZ_WORD, 0, 32'h12, 32'h0, 1, 32'h0, 1);
    run_op("l2_lbu",  1, 1, 0, SZ_BYTE, 1, 32'h13, 32'h0, 1, 32'h00000011, 0);
    @(posedge clk);
    #1;
    idle(1);

    // LAT=3: reset in the second WAIT cycle drops the pending store.
    run_op("l3_sw9", 2, 0, 1, SZ_WORD, 0, 32'h30, 32'h9, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    drive(2, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h5, 1'b0);
    @(negedge clk);
    check("l3_idle_stall", 32'(stl[2]), 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("l3_wait1_stall", 32'(stl[2]), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("l3_rst_stall", 32'(stl[2]), 32'h0);
    check("l3_rst_rw", 32'(rwo[2]), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);
    @(negedge clk);
    check("l3_post_stall", 32'(stl[2]), 32'h0);
    // A fresh full-length count proves the FSM restarted from IDLE.
    run_op("l3_lw", 2, 1, 0, SZ_WORD, 0, 32'h30, 32'h0, 1, 32'h9, 0);
    @(posedge clk);
    #1;
    idle(2);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
